nbj_redirect_pipe: RTL

Clocked, parametrised successor of the non-branch-jump processing stage in the instruction fetch path. It merges fetch groups from the front end with redirect corrections from the back end, and buffers corrections in a FIFO of configurable depth. For each fetch group it computes the next PC and cut position over a configurable slot count. It emits one result per cycle through a registered valid/ready output, and drops wrong-path fetch groups after a flush correction.

---
 rtl/nbj_pkg.sv | 23 ++
 rtl/nbj_corr_fifo.sv | 49 ++++
 rtl/nbj_redirect_pipe.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/nbj_pkg.sv
// Shared types for the non-branch-jump redirect pipe: slot type codes, correction entry layout, output register state.
package nbj_pkg;

    localparam int TYPE_W = 3;
    localparam logic [TYPE_W-1:0] TYPE_NONE = 3'd0;

    localparam int PC_W_DEF  = 32;
    localparam int IDX_W_DEF = 4;

    typedef struct packed {
        logic                 flush;
        logic [IDX_W_DEF-1:0] index;
        logic [PC_W_DEF-1:0]  pc;
    } nbj_corr_t;

    localparam int CORR_W = $bits(nbj_corr_t);

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/nbj_corr_fifo.sv
// Purpose: correction buffer, power-of-two depth, count register separates full from empty.
// Latency: an entry is visible at the head the cycle after its push (no bypass).
// Backpressure: full_o stays high for the whole cycle even if a pop happens; pushes while full are ignored.
module nbj_corr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_dat_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push, do_pop;

    assign full_o     = (cnt_q == CNT_W'(DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign do_push    = push_i & ~full_o;
    assign do_pop     = pop_i & ~empty_o;
    assign head_dat_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      cnt_q <= cnt_q + CNT_W'(1);
            else if (do_pop && !do_push) cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Storage needs no reset: the count register gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/nbj_redirect_pipe.sv
// Purpose: merge fetch groups and back-end corrections into one next-PC/cut result stream.
// Latency: front group -> result 1 cycle; correction -> result 2 cycles (through the FIFO).
// Backpressure: registered valid/ready output; readies depend only on state, i_ready and rst.
module nbj_redirect_pipe
    import nbj_pkg::*;
#(
    parameter int SLOTS      = 10,
    parameter int PC_W       = 32,
    parameter int CORR_DEPTH = 4,
    parameter int IDX_W      = $clog2(SLOTS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_front_valid,
    output logic                    o_front_ready,
    input  logic [PC_W-1:0]         i_front_pc,
    input  logic [IDX_W:0]          i_front_valid_size,
    input  logic [SLOTS*TYPE_W-1:0] i_front_type,
    input  logic [SLOTS*PC_W-1:0]   i_front_target,
    input  logic                    i_corr_valid,
    output logic                    o_corr_ready,
    input  logic                    i_corr_flush,
    input  logic [IDX_W-1:0]        i_corr_index,
    input  logic [PC_W-1:0]         i_corr_pc,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [PC_W-1:0]         o_next_pc,
    output logic [IDX_W:0]          o_cut_index,
    output logic                    o_redirect
);
    localparam int CW    = IDX_W + 1;
    localparam int ENT_W = 1 + IDX_W + PC_W;

    out_state_t      state_q, state_d;
    logic [PC_W-1:0] next_pc_q, next_pc_d;
    logic [CW-1:0]   cut_q, cut_d;
    logic            redirect_q, redirect_d;
    logic            drop_q, drop_d;

    logic             fifo_full, fifo_empty;
    logic             corr_push, corr_pop, load_ok, front_acc;
    logic [ENT_W-1:0] head;
    logic             head_flush;
    logic [IDX_W-1:0] head_idx;
    logic [PC_W-1:0]  head_pc;

    logic [CW-1:0]    front_n;
    logic [IDX_W:0]   jump;
    logic             jump_hit;
    logic [IDX_W-1:0] jump_idx;
    logic [PC_W-1:0]  front_next_pc;
    logic [CW-1:0]    front_cut;

    // Returns {hit, index} of the lowest occupied slot below n holding a jump.
    function automatic logic [IDX_W:0] first_jump(input logic [SLOTS*TYPE_W-1:0] types,
                                                  input logic [CW-1:0] n);
        logic [IDX_W:0] res;
        res = '0;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            if (k < int'(n) && types[k*TYPE_W +: TYPE_W] != TYPE_NONE) res = {1'b1, IDX_W'(k)};
        end
        return res;
    endfunction

    assign front_n       = (i_front_valid_size > CW'(SLOTS)) ? CW'(SLOTS) : i_front_valid_size;
    assign jump          = first_jump(i_front_type, front_n);
    assign jump_hit      = jump[IDX_W];
    assign jump_idx      = jump[IDX_W-1:0];
    assign front_next_pc = jump_hit ? i_front_target[jump_idx*PC_W +: PC_W]
                                    : i_front_pc + (PC_W'(front_n) << 2);
    assign front_cut     = jump_hit ? CW'(jump_idx) + CW'(1) : front_n;

    assign {head_flush, head_idx, head_pc} = head;

    assign load_ok       = (state_q == OUT_EMPTY) | i_ready;
    assign corr_pop      = load_ok & ~fifo_empty;
    assign o_corr_ready  = rst & ~fifo_full;
    assign corr_push     = i_corr_valid & o_corr_ready;
    // While a wrong-path group is owed, the front is drained even if the output is stalled.
    assign o_front_ready = rst & fifo_empty & (drop_q | load_ok);
    assign front_acc     = i_front_valid & o_front_ready;

    nbj_corr_fifo #(
        .DEPTH (CORR_DEPTH),
        .WIDTH (ENT_W)
    ) u_corr_fifo (
        .clk        (clk),
        .rst_n      (rst),
        .push_i     (corr_push),
        .push_dat_i ({i_corr_flush, i_corr_index, i_corr_pc}),
        .pop_i      (corr_pop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_dat_o (head)
    );

    always_comb begin
        state_d    = state_q;
        next_pc_d  = next_pc_q;
        cut_d      = cut_q;
        redirect_d = redirect_q;
        drop_d     = drop_q;
        if (state_q == OUT_FULL && i_ready) state_d = OUT_EMPTY;
        if (corr_pop) begin
            state_d    = OUT_FULL;
            next_pc_d  = head_pc;
            cut_d      = CW'(head_idx) + CW'(1);
            redirect_d = 1'b1;
            if (head_flush) drop_d = 1'b1;
        end else if (front_acc) begin
            if (drop_q) begin
                drop_d = 1'b0;
            end else begin
                state_d    = OUT_FULL;
                next_pc_d  = front_next_pc;
                cut_d      = front_cut;
                redirect_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= OUT_EMPTY;
            next_pc_q  <= '0;
            cut_q      <= '0;
            redirect_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            next_pc_q  <= next_pc_d;
            cut_q      <= cut_d;
            redirect_q <= redirect_d;
            drop_q     <= drop_d;
        end
    end

    assign o_valid     = (state_q == OUT_FULL);
    assign o_next_pc   = next_pc_q;
    assign o_cut_index = cut_q;
    assign o_redirect  = redirect_q;

endmodule
